// File: rtl/bram_wave_pkg.sv
// Shared definitions for the waveform BRAM read sequencer.
// Holds the sequencer state encoding, default bus widths and the
// sample record type that travels through the output buffer.
package bram_wave_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wave_state_e;

    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } sample_rec_t;

endpackage

// File: rtl/wave_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports: clk, rst (sync, active-high); push/push_data write side;
// pop/pop_data read side (pop_data shows the head entry, zero when empty);
// empty flag and count (current occupancy).
// DEPTH must be a power of two so the pointers wrap naturally.
module wave_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             wr_s;
    logic             rd_s;

    // Qualify requests: pop only with data present, push only with room (or a same-cycle pop).
    always_comb begin
        rd_s = pop & (count_r != {CNT_W{1'b0}});
        wr_s = push & ((count_r != CNT_W'(DEPTH)) | rd_s);
    end

    // Storage array write; contents need no reset because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_s, rd_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head view; forced to zero when empty so stale entries never leak out.
    always_comb begin
        empty = (count_r == {CNT_W{1'b0}});
        count = count_r;
        if (empty) begin
            pop_data = {WIDTH{1'b0}};
        end else begin
            pop_data = mem_r[rd_ptr_r];
        end
    end

    wave_sync_fifo_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd_s),
        .count (count_r)
    );

endmodule

// File: rtl/wave_sync_fifo_chk.sv
// Property checker for wave_sync_fifo.
// Ports: clk/rst as the FIFO; push request, effective pop and the FIFO
// occupancy. Flags any push that would land on a full buffer.
module wave_sync_fifo_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count
);

    // Overflow watch: the upstream credit scheme must never push into a full buffer.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (count == CNT_W'(DEPTH))));
        end
    end

endmodule

// File: rtl/bram_wave_reader.sv
// Read-side sequencer for a 256x16 waveform BRAM.
// Sweeps start_addr..end_addr (inclusive) by step, one-shot or looping,
// hides the two-edge RAM read latency and streams samples on a
// valid/ready port.
// Ports:
//   clk, rst             clock (also RAM RCLK), sync active-high reset
//   start, stop          sweep control pulses
//   loop_mode, start_addr, end_addr, step   sweep config, latched on start
//   raddr, read_en, rclke, rdata            RAM read port
//   sample_data/valid/ready/last            output stream
//   busy, cfg_err        status
module bram_wave_reader
    import bram_wave_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [ADDR_W-1:0] step,
    output logic [ADDR_W-1:0] raddr,
    output logic              read_en,
    output logic              rclke,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              sample_last,
    output logic              busy,
    output logic              cfg_err
);

    // Occupancy width leaves headroom for FIFO_DEPTH plus two in-flight reads.
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REC_W = DATA_W + 1;

    wave_state_e       state_r;
    wave_state_e       state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] cfg_start_r;
    logic [ADDR_W-1:0] cfg_end_r;
    logic [ADDR_W-1:0] cfg_step_r;
    logic              cfg_loop_r;
    logic [ADDR_W-1:0] raddr_r;
    logic [1:0]        pipe_v_r;
    logic [1:0]        pipe_last_r;
    logic              busy_r;
    logic              cfg_err_r;
    logic              cfg_err_s;
    logic              latch_s;
    logic              issue_s;
    logic              issue_last_s;
    logic              credit_ok_s;
    logic [ADDR_W:0]   nxt_s;
    logic [CNT_W-1:0]  used_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    logic              pop_s;
    logic [REC_W-1:0]  fifo_out_s;

    // Credit check: reads in flight plus buffered samples must leave a free slot.
    always_comb begin
        used_s      = CNT_W'(pipe_v_r[0]) + CNT_W'(pipe_v_r[1]) + fifo_count_s;
        credit_ok_s = (used_s < CNT_W'(FIFO_DEPTH));
        // One extra bit so a step past the top of the address space is still seen as overshoot.
        nxt_s       = {1'b0, addr_r} + {1'b0, cfg_step_r};
    end

    // Next-state, address generation and read issue.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        latch_s      = 1'b0;
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        cfg_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (start_addr <= end_addr) begin
                        state_s = ST_RUN;
                        latch_s = 1'b1;
                        addr_s  = start_addr;
                    end else begin
                        cfg_err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_s = ST_DRAIN;
                end else if (credit_ok_s) begin
                    issue_s = 1'b1;
                    if (nxt_s > {1'b0, cfg_end_r}) begin
                        if (cfg_loop_r) begin
                            addr_s = cfg_start_r;
                        end else begin
                            issue_last_s = 1'b1;
                            state_s      = ST_DRAIN;
                        end
                    end else begin
                        addr_s = nxt_s[ADDR_W-1:0];
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((pipe_v_r == 2'b00) && fifo_empty_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, config latch, RAM port registers and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            cfg_start_r <= {ADDR_W{1'b0}};
            cfg_end_r   <= {ADDR_W{1'b0}};
            cfg_step_r  <= {{(ADDR_W-1){1'b0}}, 1'b1};
            cfg_loop_r  <= 1'b0;
            raddr_r     <= {ADDR_W{1'b0}};
            pipe_v_r    <= 2'b00;
            pipe_last_r <= 2'b00;
            busy_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            if (latch_s) begin
                cfg_start_r <= start_addr;
                cfg_end_r   <= end_addr;
                cfg_loop_r  <= loop_mode;
                // A zero step would never advance; run it as a unit step.
                cfg_step_r  <= (step == {ADDR_W{1'b0}}) ? {{(ADDR_W-1){1'b0}}, 1'b1} : step;
            end
            if (issue_s) begin
                raddr_r <= addr_r;
            end
            // Stage 0 mirrors read_en; stage 1 marks rdata valid for the next edge's push.
            pipe_v_r    <= {pipe_v_r[0], issue_s};
            pipe_last_r <= {pipe_last_r[0], issue_last_s};
            busy_r      <= (state_s != ST_IDLE);
            cfg_err_r   <= cfg_err_s;
        end
    end

    assign pop_s = sample_valid & sample_ready;

    wave_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_v_r[1]),
        .push_data ({pipe_last_r[1], rdata}),
        .pop       (pop_s),
        .pop_data  (fifo_out_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign raddr        = raddr_r;
    assign read_en      = pipe_v_r[0];
    assign rclke        = busy_r;
    assign busy         = busy_r;
    assign cfg_err      = cfg_err_r;
    assign sample_valid = ~fifo_empty_s;
    assign sample_data  = fifo_out_s[DATA_W-1:0];
    assign sample_last  = fifo_out_s[DATA_W];

endmodule

// File: tb/tb_bram_wave_reader.sv
module tb_bram_wave_reader;
    import bram_wave_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loop_mode;
    logic [7:0]  start_addr;
    logic [7:0]  end_addr;
    logic [7:0]  step;
    logic [7:0]  raddr;
    logic        read_en;
    logic        rclke;
    logic [15:0] rdata = 16'd0;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        sample_last;
    logic        busy;
    logic        cfg_err;

    logic [15:0] mem [256];
    int          errors = 0;
    int          checks = 0;
    int          rd_count = 0;
    sample_rec_t got_q [$];
    sample_rec_t exp_q [$];

    bram_wave_reader #(.ADDR_W(8), .DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_mode(loop_mode),
        .start_addr(start_addr), .end_addr(end_addr), .step(step),
        .raddr(raddr), .read_en(read_en), .rclke(rclke), .rdata(rdata),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_last(sample_last), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // SB_RAM256x16 read port: RDATA updates one edge after RE is sampled with RCLKE.
    always @(posedge clk) begin
        if (rclke && read_en) rdata <= mem[raddr];
    end

    // Monitor mid-cycle: handshakes and reads that the next rising edge will commit.
    always @(negedge clk) begin
        sample_rec_t r;
        if (!rst) begin
            if (read_en) rd_count++;
            if (sample_valid && sample_ready) begin
                r.data = sample_data;
                r.last = sample_last;
                got_q.push_back(r);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: walk the sweep with unbounded integers, mem[a] = 3*a mod 2^16.
    task automatic build_exp(input int s, input int e, input int st, input bit lp, input int n);
        int a;
        sample_rec_t r;
        exp_q.delete();
        if (st == 0) st = 1;
        a = s;
        while (exp_q.size() < n) begin
            r.data = 16'((3 * a) % 65536);
            r.last = !lp && (a + st > e);
            exp_q.push_back(r);
            if (a + st > e) begin
                if (!lp) break;
                a = s;
            end else begin
                a = a + st;
            end
        end
    endtask

    task automatic clear_mon;
        got_q.delete();
        rd_count = 0;
    endtask

    task automatic do_start(input int s, input int e, input int st, input bit lp);
        start_addr = 8'(s);
        end_addr   = 8'(e);
        step       = 8'(st);
        loop_mode  = lp;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd_ready, input string name);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(posedge clk); #1;
            if (rnd_ready) sample_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        sample_ready = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b required 0 after %0d cycles", name, busy, budget);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_mode = 1'b0;
        start_addr = 8'd0; end_addr = 8'd0; step = 8'd0; sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({raddr, read_en, rclke, sample_valid, sample_last, busy, cfg_err} !== 14'd0) begin
            errors++;
            $display("FAIL reset_ctrl: raddr=%0d re=%b rclke=%b v=%b last=%b busy=%b err=%b required all 0",
                     raddr, read_en, rclke, sample_valid, sample_last, busy, cfg_err);
        end
        checks++;
        if (sample_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: sample_data=%0d required 0", sample_data);
        end
    endtask

    task automatic test_oneshot;
        bit exp_re, exp_v, exp_b;
        clear_mon();
        sample_ready = 1'b1;
        do_start(2, 5, 1, 1'b0);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_re = (k >= 1 && k <= 4);
            exp_v  = (k >= 3 && k <= 6);
            exp_b  = (k <= 7);
            checks++;
            if (read_en !== exp_re || sample_valid !== exp_v) begin
                errors++;
                $display("FAIL oneshot_timing[%0d]: re=%b valid=%b required re=%b valid=%b",
                         k, read_en, sample_valid, exp_re, exp_v);
            end
            if (k >= 1) begin
                checks++;
                if (busy !== exp_b || rclke !== exp_b) begin
                    errors++;
                    $display("FAIL oneshot_busy[%0d]: busy=%b rclke=%b required %b", k, busy, rclke, exp_b);
                end
            end
            if (exp_re) begin
                checks++;
                if (raddr !== 8'(1 + k)) begin
                    errors++;
                    $display("FAIL oneshot_raddr[%0d]: raddr=%0d required %0d", k, raddr, 1 + k);
                end
            end
        end
        build_exp(2, 5, 1, 1'b0, 1000);
        checks++;
        if (got_q.size() != exp_q.size() || rd_count != 4) begin
            errors++;
            $display("FAIL oneshot_count: samples=%0d reads=%0d required %0d and 4", got_q.size(), rd_count, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL oneshot_sample[%0d]: got %0d last=%b required %0d last=%b",
                         i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_loop_stop;
        int n = 0;
        int snap;
        clear_mon();
        sample_ready = 1'b1;
        do_start(250, 255, 2, 1'b1);
        while (got_q.size() < 7 && n < 100) begin @(posedge clk); #1; n++; end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        snap = rd_count;
        checks++;
        if (read_en !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop_re: read_en=%b required 0 after stop", read_en);
        end
        wait_idle(100, 1'b0, "loop");
        build_exp(250, 255, 2, 1'b1, got_q.size());
        checks++;
        if (got_q.size() < 7 || got_q.size() != rd_count || rd_count != snap) begin
            errors++;
            $display("FAIL loop_drain: samples=%0d reads=%0d reads_at_stop=%0d required >=7 and all equal",
                     got_q.size(), rd_count, snap);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL loop_sample[%0d]: got %0d last=%b required %0d last=0",
                         i, got_q[i].data, got_q[i].last, exp_q[i].data);
            end
        end
    endtask

    task automatic test_backpressure;
        int max_out = 0;
        int outst = 0;
        bit held = 1'b0;
        sample_rec_t hold;
        clear_mon();
        sample_ready = 1'b1;
        do_start(0, 15, 1, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        sample_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            outst = rd_count + int'(read_en) - got_q.size();
            if (outst > max_out) max_out = outst;
            if (held) begin
                checks++;
                if (sample_valid !== 1'b1 || sample_data !== hold.data || sample_last !== hold.last) begin
                    errors++;
                    $display("FAIL bp_stable[%0d]: valid=%b data=%0d required 1 data=%0d", k, sample_valid, sample_data, hold.data);
                end
            end else if (sample_valid === 1'b1) begin
                held = 1'b1;
                hold.data = sample_data;
                hold.last = sample_last;
            end
        end
        checks++;
        if (max_out > 4 || outst != 4 || read_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_credit: max_outstanding=%0d final=%0d re=%b required <=4, 4, 0", max_out, outst, read_en);
        end
        sample_ready = 1'b1;
        wait_idle(100, 1'b0, "bp");
        build_exp(0, 15, 1, 1'b0, 1000);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count: samples=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_sample[%0d]: got %0d last=%b required %0d last=%b",
                         i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    // Fixed step cases plus randomized one-shot sweeps under random backpressure.
    task automatic test_step_random;
        int s, e, st;
        for (int it = 0; it < 8; it++) begin
            if (it == 0) begin s = 0; e = 10; st = 4; end
            else if (it == 1) begin s = 7; e = 11; st = 0; end
            else if (it == 2) begin s = 250; e = 255; st = 7; end
            else begin
                s  = $urandom_range(0, 220);
                e  = s + $urandom_range(0, 35);
                st = $urandom_range(0, 6);
            end
            clear_mon();
            sample_ready = 1'b1;
            do_start(s, e, st, 1'b0);
            wait_idle(2000, (it >= 3), "step");
            build_exp(s, e, st, 1'b0, 1000);
            checks++;
            if (got_q.size() != exp_q.size() || rd_count != exp_q.size()) begin
                errors++;
                $display("FAIL step_count(s=%0d e=%0d st=%0d): samples=%0d reads=%0d required %0d",
                         s, e, st, got_q.size(), rd_count, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL step_sample(s=%0d e=%0d st=%0d)[%0d]: got %0d last=%b required %0d last=%b",
                             s, e, st, i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
                end
            end
        end
    endtask

    task automatic test_cfg_err_busy_start;
        clear_mon();
        sample_ready = 1'b1;
        do_start(9, 3, 1, 1'b0);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse: cfg_err=%b busy=%b required 1 and 0", cfg_err, busy);
        end
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0 || rd_count != 0) begin
            errors++;
            $display("FAIL cfg_err_after: cfg_err=%b busy=%b reads=%0d required 0 0 0", cfg_err, busy, rd_count);
        end
        clear_mon();
        do_start(2, 5, 1, 1'b0);
        @(posedge clk); #1;
        do_start(100, 120, 3, 1'b1);
        wait_idle(200, 1'b0, "busy_start");
        build_exp(2, 5, 1, 1'b0, 1000);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL busy_start_count: samples=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL busy_start_sample[%0d]: got %0d required %0d", i, got_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid;
        clear_mon();
        sample_ready = 1'b0;
        do_start(0, 15, 1, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({sample_valid, read_en, busy, rclke, sample_last, cfg_err} !== 6'd0 || sample_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b re=%b busy=%b rclke=%b last=%b data=%0d required all 0",
                     sample_valid, read_en, busy, rclke, sample_last, sample_data);
        end
        rst = 1'b0;
        clear_mon();
        sample_ready = 1'b1;
        do_start(4, 8, 1, 1'b0);
        wait_idle(200, 1'b0, "replay");
        build_exp(4, 8, 1, 1'b0, 1000);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL replay_count: samples=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL replay_sample[%0d]: got %0d last=%b required %0d last=%b",
                         i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'((3 * i) % 65536);
        test_reset();
        test_oneshot();
        test_loop_stop();
        test_backpressure();
        test_step_random();
        test_cfg_err_busy_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
